// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - execute stage of a 5-stage RISC-V pipeline with E/M register
//
// Purpose: forwards operands, runs the ALU, resolves branch/jump redirect and
// registers the results into the memory stage.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   *E controls        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUControlE
//   RD1_E, RD2_E       register operands; Imm_Ext_E sign-extended immediate
//   PCE, PCPlus4E      instruction PC and PC+4; RD_E destination register
//   ForwardAE/BE       forwarding selects; ResultW writeback result
//   PCSrcE, PCTargetE  combinational fetch redirect and target
//   *M outputs         registered controls, RD_M, ALUResultM, WriteDataM, PCPlus4M

module execute_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic [3:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      shamt;
    logic            zero;

    // ALUResultM is the pre-edge register value, so an EX->EX forward sees
    // the previous instruction's result even on the edge that overwrites it.
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
    assign shamt = src_b[4:0];

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            4'b0000: alu_result = src_a & src_b;
            4'b0001: alu_result = src_a | src_b;
            4'b0010: alu_result = src_a + src_b;
            4'b0011: alu_result = src_a ^ src_b;
            4'b0110: alu_result = src_a - src_b;
            4'b0111: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b1000: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'b0100: alu_result = src_a << shamt;
            4'b0101: alu_result = src_a >> shamt;
            4'b1001: alu_result = $unsigned($signed(src_a) >>> shamt);
            default: alu_result = '0;
        endcase
    end

    assign zero      = (alu_result == '0);
    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = (BranchE & zero) | JumpE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= alu_result;
            // Store data is always the forwarded register value, never the immediate.
            WriteDataM <= fwd_b;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - directed self-checking bench for execute_cycle

module tb_execute_cycle;

    logic        clk;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int checks = 0;
    int errors = 0;

    execute_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_m_zero(input string tag);
        check({tag, " RegWriteM"},  {31'd0, RegWriteM},  32'd0);
        check({tag, " MemWriteM"},  {31'd0, MemWriteM},  32'd0);
        check({tag, " ResultSrcM"}, {31'd0, ResultSrcM}, 32'd0);
        check({tag, " RD_M"},       {27'd0, RD_M},       32'd0);
        check({tag, " ALUResultM"}, ALUResultM,          32'd0);
        check({tag, " WriteDataM"}, WriteDataM,          32'd0);
        check({tag, " PCPlus4M"},   PCPlus4M,            32'd0);
    endtask

    task automatic clear_inputs();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0;
        BranchE = 0; JumpE = 0; ALUControlE = 4'b0000;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0;
        RD_E = 0; ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        #1;
        check_m_zero("reset");
        tick();
        check_m_zero("reset held");

        @(negedge clk);
        rst = 1'b1;

        // ADD 5 + 7
        RegWriteE = 1; RD_E = 5'd3; PCPlus4E = 32'h24;
        RD1_E = 5; RD2_E = 7; ALUControlE = 4'b0010;
        tick();
        check("add result", ALUResultM, 32'd12);
        check("add wdata", WriteDataM, 32'd7);
        check("add regwrite", {31'd0, RegWriteM}, 32'd1);
        check("add rd", {27'd0, RD_M}, 32'd3);
        check("add pc4", PCPlus4M, 32'h24);

        // ADDI with A from writeback; store data stays RD2, not the immediate
        clear_inputs();
        MemWriteE = 1; ResultSrcE = 1; ForwardAE = 2'b01; ResultW = 100;
        ALUSrcE = 1; Imm_Ext_E = 32'hFFFF_FFFC; RD2_E = 32'h55; ALUControlE = 4'b0010;
        tick();
        check("addi fwdW result", ALUResultM, 32'd96);
        check("addi wdata", WriteDataM, 32'h55);
        check("addi memwrite", {31'd0, MemWriteM}, 32'd1);
        check("addi resultsrc", {31'd0, ResultSrcM}, 32'd1);
        check("addi regwrite bubble", {31'd0, RegWriteM}, 32'd0);

        // Back-to-back EX->EX forwarding uses pre-edge ALUResultM
        clear_inputs();
        ForwardAE = 2'b10; ALUSrcE = 1; Imm_Ext_E = 1; ALUControlE = 4'b0010;
        tick();
        check("fwdM a 1", ALUResultM, 32'd97);
        ForwardBE = 2'b10;
        tick();
        check("fwdM a 2", ALUResultM, 32'd98);
        check("fwdM b wdata", WriteDataM, 32'd97);

        // SUB with B forwarded from writeback
        clear_inputs();
        RD1_E = 150; ForwardBE = 2'b01; ResultW = 100; ALUControlE = 4'b0110;
        tick();
        check("sub fwdW b", ALUResultM, 32'd50);
        check("sub wdata", WriteDataM, 32'd100);

        // Branch / jump redirect, combinational
        clear_inputs();
        BranchE = 1; ALUControlE = 4'b0110; RD1_E = 9; RD2_E = 9;
        PCE = 32'h40; Imm_Ext_E = 32'h10;
        #1;
        check("beq taken pcsrc", {31'd0, PCSrcE}, 32'd1);
        check("beq target", PCTargetE, 32'h50);
        RD2_E = 8;
        #1;
        check("beq not taken", {31'd0, PCSrcE}, 32'd0);
        BranchE = 0; JumpE = 1;
        #1;
        check("jump", {31'd0, PCSrcE}, 32'd1);
        PCE = 32'hFFFF_FFF0; Imm_Ext_E = 32'h20;
        #1;
        check("target wrap", PCTargetE, 32'h10);

        // Compares, wrap, logic, shifts, undefined op
        clear_inputs();
        RD1_E = 32'hFFFF_FFFF; RD2_E = 1; ALUControlE = 4'b0111;
        tick();
        check("slt", ALUResultM, 32'd1);
        ALUControlE = 4'b1000;
        tick();
        check("sltu", ALUResultM, 32'd0);
        ALUControlE = 4'b0010;
        tick();
        check("add wrap", ALUResultM, 32'd0);
        RD1_E = 32'h0000_F0F0; RD2_E = 32'h0000_0FF0; ALUControlE = 4'b0011;
        tick();
        check("xor", ALUResultM, 32'h0000_FF00);
        ALUControlE = 4'b0000;
        tick();
        check("and", ALUResultM, 32'h0000_00F0);
        ALUControlE = 4'b0001;
        tick();
        check("or", ALUResultM, 32'h0000_FFF0);
        ALUControlE = 4'b1111;
        tick();
        check("undefined op", ALUResultM, 32'd0);
        RD1_E = 32'h8000_0000; ALUSrcE = 1; Imm_Ext_E = 32'h0000_0024; ALUControlE = 4'b0101;
        tick();
        check("srl shamt[4:0]", ALUResultM, 32'h0800_0000);
        ALUControlE = 4'b1001; RegWriteE = 1; RD_E = 5'd31; PCPlus4E = 32'h88;
        tick();
        check("sra", ALUResultM, 32'hF800_0000);
        RD1_E = 32'h0000_0001; ALUControlE = 4'b0100;
        tick();
        check("sll", ALUResultM, 32'h0000_0010);
        check("sll regwrite", {31'd0, RegWriteM}, 32'd1);

        // Mid-operation asynchronous reset
        @(negedge clk);
        rst = 1'b0;
        PCE = 32'h100; Imm_Ext_E = 32'h20;
        #1;
        check_m_zero("async reset");
        check("target in reset", PCTargetE, 32'h120);
        tick();
        check_m_zero("reset across edge");
        @(negedge clk);
        rst = 1'b1;
        RD1_E = 32'd40; ALUSrcE = 1; Imm_Ext_E = 32'd2; ALUControlE = 4'b0010;
        MemWriteE = 1; RD_E = 5'd7; PCPlus4E = 32'h200; RD2_E = 32'h33;
        #1;
        check_m_zero("released pre-edge");
        tick();
        check("post-reset result", ALUResultM, 32'd42);
        check("post-reset wdata", WriteDataM, 32'h33);
        check("post-reset rd", {27'd0, RD_M}, 32'd7);
        check("post-reset pc4", PCPlus4M, 32'h200);
        check("post-reset memwrite", {31'd0, MemWriteM}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 RegWriteE  in  1  register-file write enable from decode.
REQ-005 ALUSrcE  in  1  ALU operand B select: 1 = Imm_Ext_E, 0 = forwarded RD2.
REQ-006 MemWriteE  in  1  data-memory write enable.
REQ-007 ResultSrcE  in  1  writeback select: 1 = memory data, 0 = ALU result.
REQ-008 BranchE  in  1  conditional branch (BEQ).
REQ-009 JumpE  in  1  unconditional jump.
REQ-010 ALUControlE  in  4  ALU operation code.
REQ-011 RD1_E, RD2_E  in  32 each  register operands.
REQ-012 Imm_Ext_E  in  32  sign-extended immediate.
REQ-013 PCE, PCPlus4E  in  32 each  instruction PC and PC+4.
REQ-014 RD_E  in  5  destination register.
REQ-015 ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit.
REQ-016 ResultW  in  32  writeback-stage result, used for forwarding.
REQ-017 PCSrcE  out  1  redirect fetch to PCTargetE (combinational).
REQ-018 PCTargetE  out  32  branch/jump target (combinational).
REQ-019 RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered control signals.
REQ-020 RD_M  out  5  registered destination register.
REQ-021 ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered ALU result, store data, and PC+4.

Function
REQ-022 SrcA is selected by ForwardAE: 00 = RD1_E, 01 = ResultW, 10 = ALUResultM (this block's registered output), 11 = RD1_E.
REQ-023 Forwarded B is selected by ForwardBE using the same encoding applied to RD2_E.
REQ-024 SrcB is Imm_Ext_E when ALUSrcE = 1, otherwise forwarded B.
REQ-025 ALU operations by ALUControlE:
- 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0110 SUB.
- 0111 SLT (signed): result is 1 or 0, zero-extended.
- 1000 SLTU (unsigned): result is 1 or 0, zero-extended.
- 0100 SLL; 0101 SRL; 1001 SRA; shift amount is SrcB[4:0].
- Any other code yields 0.
REQ-026 Add and subtract wrap modulo 2^32; no overflow flag is produced.
REQ-027 ZeroE is 1 exactly when the ALU result equals 0.
REQ-028 PCTargetE = PCE + Imm_Ext_E, modulo 2^32.
REQ-029 PCSrcE = (BranchE AND ZeroE) OR JumpE; no registering.
REQ-030 The E/M register loads on every rising clk edge when rst is high.
- Loaded values: RegWriteE, MemWriteE, ResultSrcE, RD_E, ALU result, forwarded B (to WriteDataM), PCPlus4E.
- The register has no stall or enable; latency is exactly 1 cycle from E inputs to M outputs.
REQ-031 WriteDataM is forwarded B, never the immediate, regardless of ALUSrcE.
REQ-032 When ForwardAE = 10 and the M register updates on the same edge, SrcA uses the pre-edge ALUResultM value.
REQ-033 Bubbles arriving from decode (all controls 0) propagate as RegWriteM = 0 and MemWriteM = 0; no special handling is required.

Reset
REQ-034 rst low asynchronously clears all M outputs to 0, independent of clk.
REQ-035 While rst is low, the M outputs hold 0; PCSrcE and PCTargetE remain combinational functions of the inputs.
REQ-036 Reset asserted mid-operation discards the in-flight E/M contents; the first edge after rst rises loads the current E inputs.

Verification
REQ-037 ADD: RD1_E=5, RD2_E=7, ALUControlE=0010, ALUSrcE=0, Forward=00 -> next edge ALUResultM=12, WriteDataM=7.
REQ-038 Forwarding:
- ForwardAE=01 with ResultW=100, ADDI with Imm=-4 (ALUSrcE=1) -> ALUResultM=96.
- Back-to-back, ForwardAE=10 -> the previous ALUResultM is used.
REQ-039 BEQ taken: BranchE=1, SUB, RD1_E=RD2_E=9, PCE=0x40, Imm=0x10 -> PCSrcE=1, PCTargetE=0x50 in the same cycle.
REQ-040 BEQ not taken: RD1_E=9, RD2_E=8 -> PCSrcE=0.
REQ-041 Jump: JumpE=1 -> PCSrcE=1 regardless of ZeroE.
REQ-042 Signed versus unsigned compare: SLT with 0xFFFFFFFF vs 1 -> 1; SLTU with the same operands -> 0.
REQ-043 Wrap: ADD 0xFFFFFFFF + 1 -> 0.
REQ-044 Shift: SRA of 0x80000000 by 4 -> 0xF8000000.
REQ-045 Reset: assert rst low between clock edges -> all M outputs 0 immediately; outputs stay 0 until the first edge after release.
